// File: rtl/nap_controller_if.sv
// Button, status and time-digit bundle between the button front-end, nap_controller and
// time_register. The controller takes the slave side; whoever produces the buttons takes master.
interface nap_controller_if;
    logic       btn_mode;
    logic       btn_up;
    logic       btn_start;
    logic       btn_stop;
    logic       btn_snooze;
    logic       complete;

    logic [3:0] setHour10;
    logic [3:0] setHour1;
    logic [3:0] setMinute10;
    logic [3:0] setMinute1;
    logic [3:0] setSecond10;
    logic [3:0] setSecond1;
    logic       write;
    logic       start;
    logic       alarm;
    logic [2:0] cursor;
    logic [2:0] state;

    modport master (
        output btn_mode,
        output btn_up,
        output btn_start,
        output btn_stop,
        output btn_snooze,
        output complete,
        input  setHour10,
        input  setHour1,
        input  setMinute10,
        input  setMinute1,
        input  setSecond10,
        input  setSecond1,
        input  write,
        input  start,
        input  alarm,
        input  cursor,
        input  state
    );

    modport slave (
        input  btn_mode,
        input  btn_up,
        input  btn_start,
        input  btn_stop,
        input  btn_snooze,
        input  complete,
        output setHour10,
        output setHour1,
        output setMinute10,
        output setMinute1,
        output setSecond10,
        output setSecond1,
        output write,
        output start,
        output alarm,
        output cursor,
        output state
    );
endinterface

// File: rtl/nap_controller.sv
// Nap timer sequencer: digit editing, load/run/pause of time_register, timed alarm.
// Snooze (and its saved-digit registers) is built only when NAP_SNOOZE_EN is defined.
module nap_controller #(
    parameter int unsigned TICKS_PER_SEC = 50000000,
    parameter int unsigned ALARM_SEC     = 30,
    parameter int unsigned SNOOZE_MIN    = 5
) (
    input logic             clock,
    input logic             reset,
    nap_controller_if.slave bus
);

    localparam int unsigned TickW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned SecW  = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;

    localparam logic [TickW-1:0] TickLast = TickW'(TICKS_PER_SEC - 1);
    localparam logic [SecW-1:0]  SecLast  = SecW'(ALARM_SEC - 1);
    localparam logic [3:0]       SnzMin10 = 4'(SNOOZE_MIN / 10);
    localparam logic [3:0]       SnzMin1  = 4'(SNOOZE_MIN % 10);
    localparam logic [2:0]       CurLast  = 3'd5;

    // Index 0 is Hour10, index 5 is Second1; limits allow up to 99:59:59.
    localparam logic [5:0][3:0] DigitMax = {4'd9, 4'd5, 4'd9, 4'd5, 4'd9, 4'd9};

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSet   = 3'd1,
        StLoad  = 3'd2,
        StRun   = 3'd3,
        StPause = 3'd4,
        StAlarm = 3'd5
`ifdef NAP_SNOOZE_EN
        ,
        StSnooze = 3'd6
`endif
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       cursor_q, cursor_d;
    logic [5:0][3:0]  digit_q, digit_d;
    logic             write_q, write_d;
    logic             start_q, start_d;
    logic             alarm_q, alarm_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic [SecW-1:0]  sec_q, sec_d;

    logic             digits_nz;
    logic             alarm_done;
    logic             go_idle;

`ifdef NAP_SNOOZE_EN
    logic [5:0][3:0]  saved_q, saved_d;
    logic             snoozed_q, snoozed_d;
`else
    logic             unused_snooze;
    assign unused_snooze = ^{bus.btn_snooze, SnzMin10, SnzMin1};
`endif

    assign digits_nz  = |digit_q;
    assign alarm_done = (tick_q == TickLast) && (sec_q == SecLast);

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        digit_d  = digit_q;
        tick_d   = tick_q;
        sec_d    = sec_q;
        go_idle  = 1'b0;
`ifdef NAP_SNOOZE_EN
        saved_d   = saved_q;
        snoozed_d = snoozed_q;
`endif

        // Stop outranks every other button, so it is handled ahead of the per-state decode.
        if (bus.btn_stop) begin
            go_idle = 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.btn_start) begin
                        if (digits_nz) state_d = StLoad;
                    end else if (bus.btn_mode) begin
                        state_d  = StSet;
                        cursor_d = '0;
                    end
                end
                StSet: begin
                    if (bus.btn_start) begin
                        if (digits_nz) state_d = StLoad;
                    end else if (bus.btn_mode) begin
                        cursor_d = (cursor_q == CurLast) ? 3'd0 : cursor_q + 3'd1;
                    end else if (bus.btn_up) begin
                        digit_d[cursor_q] = (digit_q[cursor_q] >= DigitMax[cursor_q]) ?
                                            4'd0 : digit_q[cursor_q] + 4'd1;
                    end
                end
                StLoad: begin
                    state_d = StRun;
                end
                StRun: begin
                    if (bus.btn_start) begin
                        state_d = StPause;
                    end else if (bus.complete) begin
                        state_d = StAlarm;
                    end
                end
                StPause: begin
                    if (bus.btn_start) state_d = StRun;
                end
                StAlarm: begin
`ifdef NAP_SNOOZE_EN
                    if (bus.btn_snooze) begin
                        state_d = StSnooze;
                        digit_d = {4'd0, 4'd0, SnzMin1, SnzMin10, 4'd0, 4'd0};
                        // Keep the user's original digits across repeated snoozes.
                        if (!snoozed_q) saved_d = digit_q;
                        snoozed_d = 1'b1;
                    end else
`endif
                    if (alarm_done) begin
                        go_idle = 1'b1;
                    end else if (tick_q == TickLast) begin
                        tick_d = '0;
                        sec_d  = sec_q + SecW'(1);
                    end else begin
                        tick_d = tick_q + TickW'(1);
                    end
                end
`ifdef NAP_SNOOZE_EN
                StSnooze: begin
                    state_d = StLoad;
                end
`endif
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        if (go_idle) begin
            state_d  = StIdle;
            cursor_d = '0;
`ifdef NAP_SNOOZE_EN
            if (snoozed_q) digit_d = saved_q;
            snoozed_d = 1'b0;
`endif
        end

        // Counters idle at zero so every alarm entry starts a fresh timing window.
        if (state_d != StAlarm) begin
            tick_d = '0;
            sec_d  = '0;
        end

        write_d = (state_d == StLoad);
        start_d = (state_d == StRun);
        alarm_d = (state_d == StAlarm);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cursor_q <= '0;
            digit_q  <= '0;
            write_q  <= 1'b0;
            start_q  <= 1'b0;
            alarm_q  <= 1'b0;
            tick_q   <= '0;
            sec_q    <= '0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            digit_q  <= digit_d;
            write_q  <= write_d;
            start_q  <= start_d;
            alarm_q  <= alarm_d;
            tick_q   <= tick_d;
            sec_q    <= sec_d;
        end
    end

`ifdef NAP_SNOOZE_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            saved_q   <= '0;
            snoozed_q <= 1'b0;
        end else begin
            saved_q   <= saved_d;
            snoozed_q <= snoozed_d;
        end
    end
`endif

    assign bus.setHour10   = digit_q[0];
    assign bus.setHour1    = digit_q[1];
    assign bus.setMinute10 = digit_q[2];
    assign bus.setMinute1  = digit_q[3];
    assign bus.setSecond10 = digit_q[4];
    assign bus.setSecond1  = digit_q[5];
    assign bus.write       = write_q;
    assign bus.start       = start_q;
    assign bus.alarm       = alarm_q;
    assign bus.cursor      = cursor_q;
    assign bus.state       = state_q;

endmodule
